// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out receiver: rebuilds N-bit words from a framed bit stream
// and hands them to a parallel consumer through a single-entry valid/ready register.
module shift_deserializer #(
   parameter int N = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 serial_in,
   input  logic                 serial_valid,
   input  logic                 sync,
   input  logic                 dir,
   input  logic                 q_ready,
   input  logic                 clr_ovr,
   output logic [N-1:0]         q_reg,
   output logic                 q_valid,
   output logic                 overrun,
   output logic                 locked,
   output logic [$clog2(N):0]   bit_cnt,
   output logic [15:0]          word_cnt
);

   localparam int CW = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

   typedef enum logic [0:0] {
      HUNT  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [N-1:0]    shreg_r;
   logic            dir_q_r;
   logic [CW-1:0]   bit_cnt_r;
   logic [N-1:0]    q_reg_r;
   logic            q_valid_r;
   logic            overrun_r;
   logic [15:0]     word_cnt_r;

   logic            accept_s;
   logic            dir_eff_s;
   logic [N-1:0]    shreg_base_s;
   logic [N-1:0]    shifted_s;
   logic [CW-1:0]   cnt_base_s;
   logic [CW-1:0]   cnt_nxt_s;
   logic            complete_s;
   logic            load_s;
   logic            drop_s;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= HUNT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic: sync always (re)enters SHIFT, nothing leaves it but reset
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         HUNT: begin
            if (sync) begin
               state_nxt_s = SHIFT;
            end else begin
               state_nxt_s = HUNT;
            end
         end
         SHIFT:   state_nxt_s = SHIFT;
         default: state_nxt_s = HUNT;
      endcase
   end

   // FSM output decode: bit acceptance, shift result, word completion and hand-off
   always_comb begin
      accept_s     = 1'b0;
      dir_eff_s    = dir_q_r;
      shreg_base_s = shreg_r;
      cnt_base_s   = bit_cnt_r;
      shifted_s    = shreg_r;
      cnt_nxt_s    = bit_cnt_r;
      complete_s   = 1'b0;
      load_s       = 1'b0;
      drop_s       = 1'b0;

      // A sync restarts framing: the fresh bit is bit 0 and the new order applies to it
      if (sync) begin
         dir_eff_s    = dir;
         shreg_base_s = {N{1'b0}};
         cnt_base_s   = {CW{1'b0}};
      end else begin
         dir_eff_s    = dir_q_r;
         shreg_base_s = shreg_r;
         cnt_base_s   = bit_cnt_r;
      end

      accept_s = serial_valid && (sync || (state_r == SHIFT));

      if (dir_eff_s) begin
         shifted_s = {serial_in, shreg_base_s[N-1:1]};
      end else begin
         shifted_s = {shreg_base_s[N-2:0], serial_in};
      end

      complete_s = accept_s && (cnt_base_s == LAST_BIT);
      load_s     = complete_s && (!q_valid_r || q_ready);
      drop_s     = complete_s && q_valid_r && !q_ready;

      if (complete_s) begin
         cnt_nxt_s = {CW{1'b0}};
      end else if (accept_s) begin
         cnt_nxt_s = cnt_base_s + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         cnt_nxt_s = cnt_base_s;
      end
   end

   // Shift register, latched bit order and bit counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg_r   <= {N{1'b0}};
         dir_q_r   <= 1'b0;
         bit_cnt_r <= {CW{1'b0}};
      end else begin
         if (accept_s) begin
            shreg_r <= shifted_s;
         end else if (sync) begin
            shreg_r <= {N{1'b0}};
         end else begin
            shreg_r <= shreg_r;
         end
         if (sync) begin
            dir_q_r <= dir;
         end else begin
            dir_q_r <= dir_q_r;
         end
         bit_cnt_r <= cnt_nxt_s;
      end
   end

   // Holding register, handshake, sticky overrun and saturating word counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_reg_r    <= {N{1'b0}};
         q_valid_r  <= 1'b0;
         overrun_r  <= 1'b0;
         word_cnt_r <= 16'h0000;
      end else begin
         if (load_s) begin
            q_reg_r   <= shifted_s;
            q_valid_r <= 1'b1;
            if (word_cnt_r != 16'hFFFF) begin
               word_cnt_r <= word_cnt_r + 16'h0001;
            end else begin
               word_cnt_r <= word_cnt_r;
            end
         end else if (q_valid_r && q_ready) begin
            q_valid_r <= 1'b0;
         end else begin
            q_valid_r <= q_valid_r;
         end
         // A drop outranks a simultaneous clear so no lost word goes unreported
         if (drop_s) begin
            overrun_r <= 1'b1;
         end else if (clr_ovr) begin
            overrun_r <= 1'b0;
         end else begin
            overrun_r <= overrun_r;
         end
      end
   end

   assign q_reg    = q_reg_r;
   assign q_valid  = q_valid_r;
   assign overrun  = overrun_r;
   assign locked   = (state_r == SHIFT);
   assign bit_cnt  = bit_cnt_r;
   assign word_cnt = word_cnt_r;

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer: directed scenarios plus a randomized
// run compared against a bit-queue reference model of the receiver.
module tb_shift_deserializer;

   localparam int N = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          serial_in, serial_valid, sync, dir, q_ready, clr_ovr;
   logic [N-1:0]  q_reg;
   logic          q_valid, overrun, locked;
   logic [3:0]    bit_cnt;
   logic [15:0]   word_cnt;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit            m_bits[$];
   logic [N-1:0]  m_q;
   logic          m_qv, m_ovr, m_locked, m_dir;
   logic [15:0]   m_wcnt;

   shift_deserializer #(.N(N)) dut (
      .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
      .sync(sync), .dir(dir), .q_ready(q_ready), .clr_ovr(clr_ovr),
      .q_reg(q_reg), .q_valid(q_valid), .overrun(overrun), .locked(locked),
      .bit_cnt(bit_cnt), .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_bits.delete();
      m_q = '0; m_qv = 1'b0; m_ovr = 1'b0; m_locked = 1'b0; m_dir = 1'b0; m_wcnt = 16'h0000;
   endtask

   function automatic logic [N-1:0] build_word();
      logic [N-1:0] w = '0;
      for (int i = 0; i < N; i++) begin
         if (m_dir) w[i] = m_bits[i];
         else       w[N-1-i] = m_bits[i];
      end
      return w;
   endfunction

   // Drive one cycle of inputs, advance the model, and land just after the edge.
   task automatic step(input logic s, input logic v, input logic b, input logic d,
                       input logic r, input logic c);
      logic done = 1'b0;
      logic drop = 1'b0;
      logic [N-1:0] w = '0;
      @(negedge clk);
      sync = s; serial_valid = v; serial_in = b; dir = d; q_ready = r; clr_ovr = c;
      if (s) begin
         m_locked = 1'b1; m_dir = d; m_bits.delete();
      end
      if (v && m_locked) begin
         m_bits.push_back(b);
         if (m_bits.size() == N) begin
            w = build_word(); m_bits.delete(); done = 1'b1;
         end
      end
      if (done && (!m_qv || r)) begin
         m_q = w; m_qv = 1'b1;
         if (m_wcnt != 16'hFFFF) m_wcnt = m_wcnt + 16'd1;
      end else if (done) begin
         drop = 1'b1;
      end else if (m_qv && r) begin
         m_qv = 1'b0;
      end
      if (drop) m_ovr = 1'b1;
      else if (c) m_ovr = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Send one word; dir is only meaningful on the sync cycle, so it is randomized elsewhere.
   task automatic send_word(input logic [N-1:0] w, input logic d, input logic s,
                            input logic r, input logic c_last);
      logic b;
      for (int i = 0; i < N; i++) begin
         b = d ? w[i] : w[N-1-i];
         step((i == 0) ? s : 1'b0, 1'b1, b, (i == 0 && s) ? d : 1'($urandom_range(0, 1)),
              r, (i == N-1) ? c_last : 1'b0);
      end
   endtask

   task automatic apply_reset(input int n);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (n) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      sync = 1'b0; serial_valid = 1'b0; serial_in = 1'b0; dir = 1'b0; q_ready = 1'b0; clr_ovr = 1'b0;
      apply_reset(20);
      checks++; if (q_reg !== 8'h00) begin errors++; $display("FAIL reset_q_reg got %h exp 00", q_reg); end
      checks++; if (q_valid !== 1'b0 || overrun !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL reset_flags got v=%b o=%b l=%b exp 0", q_valid, overrun, locked); end
      checks++; if (bit_cnt !== 4'd0 || word_cnt !== 16'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", bit_cnt, word_cnt); end
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
         checks++;
         if (locked !== 1'b0 || q_valid !== 1'b0 || bit_cnt !== 4'd0 || word_cnt !== 16'd0 || q_reg !== 8'h00) begin
            errors++; $display("FAIL hunt_idle got l=%b v=%b bc=%0d wc=%0d q=%h exp all 0", locked, q_valid, bit_cnt, word_cnt, q_reg);
         end
      end
   endtask

   task automatic test_msb_first();
      logic [7:0] pat = 8'h55;
      for (int i = 0; i < N; i++) begin
         step((i == 0), 1'b1, pat[N-1-i], 1'b0, 1'b1, 1'b0);
         if (i == 0) begin
            checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_on_sync got %b exp 1", locked); end
         end
         if (i < N-1) begin
            checks++; if (q_valid !== 1'b0 || bit_cnt !== 4'(i + 1)) begin errors++; $display("FAIL msb_latency edge %0d got v=%b bc=%0d exp v=0 bc=%0d", i + 1, q_valid, bit_cnt, i + 1); end
         end
      end
      checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL msb_valid got %b exp 1", q_valid); end
      checks++; if (q_reg !== 8'h55) begin errors++; $display("FAIL msb_q_reg got %h exp 55", q_reg); end
      checks++; if (word_cnt !== 16'd1 || bit_cnt !== 4'd0) begin errors++; $display("FAIL msb_counts got wc=%0d bc=%0d exp 1/0", word_cnt, bit_cnt); end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL msb_consume got %b exp 0", q_valid); end
   endtask

   task automatic test_lsb_stream();
      logic [7:0] w;
      apply_reset(3);
      for (int k = 0; k < 101; k++) begin
         w = (k == 0) ? 8'hAA : 8'($urandom_range(0, 255));
         send_word(w, 1'b1, (k == 0), 1'b1, 1'b0);
         checks++; if (q_reg !== w || q_valid !== 1'b1) begin errors++; $display("FAIL lsb_word %0d got %h v=%b exp %h v=1", k, q_reg, q_valid, w); end
      end
      checks++; if (word_cnt !== 16'd101) begin errors++; $display("FAIL lsb_word_cnt got %0d exp 101", word_cnt); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL lsb_overrun got %b exp 0", overrun); end
   endtask

   task automatic test_overrun();
      apply_reset(2);
      send_word(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (q_reg !== 8'h0F || q_valid !== 1'b1) begin errors++; $display("FAIL ovr_first got %h v=%b exp 0f v=1", q_reg, q_valid); end
      send_word(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (q_reg !== 8'h0F) begin errors++; $display("FAIL ovr_hold got %h exp 0f", q_reg); end
      checks++; if (overrun !== 1'b1 || word_cnt !== 16'd1) begin errors++; $display("FAIL ovr_set got o=%b wc=%0d exp 1/1", overrun, word_cnt); end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", overrun); end
      send_word(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_priority got %b exp 1", overrun); end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (q_valid !== 1'b0 || q_reg !== 8'h0F) begin errors++; $display("FAIL ovr_drain got v=%b q=%h exp v=0 q=0f", q_valid, q_reg); end
   endtask

   task automatic test_resync();
      apply_reset(2);
      for (int i = 0; i < 5; i++) step((i == 0), 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
      checks++; if (bit_cnt !== 4'd5) begin errors++; $display("FAIL resync_partial got %0d exp 5", bit_cnt); end
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checks++; if (bit_cnt !== 4'd0 || locked !== 1'b1) begin errors++; $display("FAIL sync_no_bit got bc=%0d l=%b exp 0/1", bit_cnt, locked); end
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
      send_word(8'hC3, 1'b0, 1'b1, 1'b1, 1'b0);
      checks++; if (q_reg !== 8'hC3 || word_cnt !== 16'd1) begin errors++; $display("FAIL resync_word got %h wc=%0d exp c3/1", q_reg, word_cnt); end
   endtask

   task automatic test_random();
      logic s, v, r, c;
      apply_reset(2);
      for (int i = 0; i < 600; i++) begin
         s = ($urandom_range(0, 24) == 0);
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) == 0);
         c = ($urandom_range(0, 9) == 0);
         step(s, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r, c);
         checks++;
         if (q_reg !== m_q || q_valid !== m_qv || overrun !== m_ovr || locked !== m_locked ||
             bit_cnt !== 4'(m_bits.size()) || word_cnt !== m_wcnt) begin
            errors++;
            $display("FAIL random cyc %0d got q=%h v=%b o=%b l=%b bc=%0d wc=%0d exp q=%h v=%b o=%b l=%b bc=%0d wc=%0d",
                     i, q_reg, q_valid, overrun, locked, bit_cnt, word_cnt,
                     m_q, m_qv, m_ovr, m_locked, m_bits.size(), m_wcnt);
         end
      end
   endtask

   task automatic test_async_reset();
      apply_reset(2);
      send_word(8'h99, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (q_valid !== 1'b1 || bit_cnt !== 4'd4) begin errors++; $display("FAIL pre_reset got v=%b bc=%0d exp 1/4", q_valid, bit_cnt); end
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if (q_reg !== 8'h00 || q_valid !== 1'b0 || overrun !== 1'b0 || locked !== 1'b0 || bit_cnt !== 4'd0 || word_cnt !== 16'd0) begin
         errors++; $display("FAIL async_reset got q=%h v=%b o=%b l=%b bc=%0d wc=%0d exp all 0", q_reg, q_valid, overrun, locked, bit_cnt, word_cnt);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 2 * N; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
      checks++; if (locked !== 1'b0 || q_valid !== 1'b0 || word_cnt !== 16'd0) begin errors++; $display("FAIL post_reset_hunt got l=%b v=%b wc=%0d exp 0/0/0", locked, q_valid, word_cnt); end
   endtask

   initial begin
      reset = 1'b1;
      model_reset();
      test_reset();
      test_msb_first();
      test_lsb_stream();
      test_overrun();
      test_resync();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-in/parallel-out receiver that rebuilds N-bit words from the one-bit stream produced by the team's `shift_register` when it runs in a shift mode. Each completed word goes into a single-entry holding register with a valid/ready handshake. The block sits at the far end of the serial link, feeding a parallel consumer. It reports word framing, bit order and overrun status.

## Interface
- N, 8, word width in bits (N ≥ 2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- serial_in  input  1  serial data bit
- serial_valid  input  1  serial_in carries a bit this cycle
- sync  input  1  start-of-word marker; qualifies the current cycle's bit as bit 0 of a new word
- dir  input  1  bit order: 0 = MSB-first, 1 = LSB-first; sampled only on sync
- q_ready  input  1  consumer accepts q_reg this cycle
- clr_ovr  input  1  clears overrun
- q_reg  output  N  assembled word
- q_valid  output  1  q_reg holds an unconsumed word
- overrun  output  1  sticky; a completed word was dropped
- locked  output  1  FSM is in SHIFT state
- bit_cnt  output  $clog2(N)+1  bits collected in the current word
- word_cnt  output  16  words delivered to the holding register, saturating at 16'hFFFF

## Operation
- FSM states are HUNT and SHIFT. Reset puts the FSM in HUNT.
- In HUNT, bits are ignored and bit_cnt = 0.
- sync = 1 in any state:
  - moves the FSM to SHIFT;
  - latches dir into dir_q;
  - discards any partial word.
- sync with serial_valid = 1: the bit is shifted in and bit_cnt becomes 1.
- sync with serial_valid = 0: bit_cnt becomes 0.
- In SHIFT, serial_valid = 1 without sync shifts one bit and increments bit_cnt.
- serial_valid = 0 holds all state. There is no timeout.
- Shift rules, applied to internal register shreg:
  - dir_q = 0: shreg ← {shreg[N-2:0], serial_in}, so the first bit lands in the MSB.
  - dir_q = 1: shreg ← {serial_in, shreg[N-1:1]}, so the first bit lands in the LSB.
  - A change on dir mid-word has no effect.
- Word completion happens when a bit is accepted with bit_cnt = N-1. Including that bit, the word is offered to the holding register and bit_cnt wraps to 0. The FSM stays in SHIFT, so back-to-back words need no further sync.
- Holding register load/drop rules:
  - Load if q_valid = 0, or if q_valid = 1 and q_ready = 1 in the same cycle. Set q_valid and increment word_cnt.
  - If q_valid = 1 and q_ready = 0, drop the new word and set overrun. q_reg and q_valid are unchanged.
- Handshake:
  - A transfer occurs on an edge with q_valid = 1 and q_ready = 1.
  - q_valid falls after the transfer unless a word completes on that same edge.
  - q_reg is stable while q_valid = 1 and q_ready = 0.
- overrun is cleared only by clr_ovr or reset. A drop in the same cycle as clr_ovr takes priority: overrun = 1.
- Reset values (asynchronous, mid-operation included): q_reg = 0, q_valid = 0, overrun = 0, locked = 0, bit_cnt = 0, word_cnt = 0, shreg = 0, dir_q = 0. A pending word is lost.

## Timing
- All outputs are registered.
- q_valid rises on the same clock edge that samples the N-th bit. Latency from the first bit to q_valid is exactly N edges when serial_valid is continuous.
- locked rises on the edge that samples sync.
- Sustained throughput is one word per N valid bits. With q_ready tied high, there is no backpressure loss.
- q_ready = 0 for longer than N valid bits after a word is presented causes overrun.
- Deassertion of reset takes effect at the first clk edge after reset goes high. The block is idle (HUNT) until sync.

## Test plan
- Reset held low for 20 cycles, released, then serial_valid with no sync → all outputs stay 0 and locked = 0.
- sync + dir = 0, then bits 0,1,0,1,0,1,0,1 continuous with q_ready = 1 → q_valid pulses 8 edges after the first bit, q_reg = 8'h55, word_cnt = 1.
- sync + dir = 1, then stream 8'hAA LSB-first and 100 random bytes back-to-back with q_ready = 1 → every q_reg matches the transmitted byte, word_cnt = 101, overrun = 0.
- Word 8'h0F completes with q_ready = 0, then a second word 8'hF0 completes → q_reg stays 8'h0F and overrun = 1. clr_ovr → overrun = 0.
- sync reasserted after 5 bits of a word, then 8 bits of 8'hC3 → partial word discarded, q_reg = 8'hC3.
- Reset asserted after 4 bits while q_valid = 1 → all outputs 0 immediately, without a clock edge. After release, HUNT with no delivery until sync.
